// File: rtl/seg_led_pkg.sv
// Shared types and constants for the seg_led_scan display driver.
// Segment order on LED: [7]=b [6]=c [5]=d [4]=e [3]=f [2]=a [1]=g [0]=dp, active-low.
package seg_led_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index 15 is leftmost so that SEG_TAB[n] decodes hex digit n.
    localparam logic [15:0][7:0] SEG_TAB = {
        8'hE1, 8'hC1, 8'h0D, 8'hC3,
        8'h85, 8'h21, 8'h11, 8'h01,
        8'h3B, 8'h81, 8'h91, 8'h35,
        8'h19, 8'h49, 8'h3F, 8'h03
    };

endpackage

// File: rtl/seg_led_hex.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
// A blanked digit turns all segments off but still honours its decimal point.
module seg_led_hex
    import seg_led_pkg::*;
(
    input  nibble_t    nib_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] led_o
);

    // Table lookup, then clear the dp bit when requested.
    always_comb begin
        led_o = blank_i ? SEG_BLANK : SEG_TAB[nib_i];
        if (dp_i) begin
            led_o[0] = 1'b0;
        end
    end

endmodule

// File: rtl/seg_led_scan.sv
// Time-multiplexed 7-segment scanner with anti-ghost blanking and frame-aligned buffering.
// Define SEG_LED_LZB_EN to blank leading zero digits (decimal points still shown).
module seg_led_scan
    import seg_led_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            LED,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);
    localparam phase_t PH_RST = (BLANK_CYCLES > 0) ? PH_BLANK : PH_SHOW;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       dig_q, dig_d;
    phase_t              state_q, state_d;
    logic [4*DIGITS-1:0] pdata_q, pdata_d, sdata_q, sdata_d;
    logic [DIGITS-1:0]   pdp_q, pdp_d, sdp_q, sdp_d;
    logic                pflag_q, pflag_d;
    logic [7:0]          led_q, led_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                fd_q, fd_d;
    logic                frame_end;
    nibble_t             nib;
    logic                dp_sel;
    logic                lz;
    logic [7:0]          hex_led;

    assign frame_end = en && (cnt_q == CNT_LAST) && (dig_q == DIG_LAST);

    // Slot prescaler and digit index; phase is the registered view of the next count.
    always_comb begin
        cnt_d = cnt_q;
        dig_d = dig_q;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        state_d = (32'(cnt_d) < 32'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
    end

    // Pending capture on load; shadow swap only at the frame boundary.
    always_comb begin
        pdata_d = pdata_q;
        pdp_d   = pdp_q;
        pflag_d = pflag_q;
        sdata_d = sdata_q;
        sdp_d   = sdp_q;
        if (load) begin
            pdata_d = data;
            pdp_d   = dp;
            pflag_d = 1'b1;
        end
        if (frame_end) begin
            pflag_d = 1'b0;
            if (load) begin
                sdata_d = data;
                sdp_d   = dp;
            end else if (pflag_q) begin
                sdata_d = pdata_q;
                sdp_d   = pdp_q;
            end
        end
    end

    // Select the current digit's nibble/dp and decide leading-zero blanking.
    always_comb begin
        nib    = '0;
        dp_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q == DW'(i)) begin
                nib    = sdata_q[4*i +: 4];
                dp_sel = sdp_q[i];
            end
        end
`ifdef SEG_LED_LZB_EN
        begin : lzb
            logic hi_zero;
            hi_zero = 1'b1;
            lz      = 1'b0;
            for (int i = DIGITS - 1; i > 0; i--) begin
                hi_zero = hi_zero & (sdata_q[4*i +: 4] == 4'h0);
                if (dig_q == DW'(i)) begin
                    lz = hi_zero;
                end
            end
        end
`else
        lz = 1'b0;
`endif
    end

    seg_led_hex u_hex (
        .nib_i   (nib),
        .dp_i    (dp_sel),
        .blank_i (lz),
        .led_o   (hex_led)
    );

    // Output next-state: dark unless enabled and in the SHOW phase.
    always_comb begin
        led_d = SEG_BLANK;
        an_d  = '1;
        fd_d  = frame_end;
        if (en && (state_q == PH_SHOW)) begin
            led_d = hex_led;
            an_d  = ~(DIGITS'(1) << dig_q);
        end
    end

    // Scan counters and phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            dig_q   <= '0;
            state_q <= PH_RST;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            state_q <= state_d;
        end
    end

    // Pending and shadow display buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdata_q <= '0;
            pdp_q   <= '0;
            pflag_q <= 1'b0;
            sdata_q <= '0;
            sdp_q   <= '0;
        end else begin
            pdata_q <= pdata_d;
            pdp_q   <= pdp_d;
            pflag_q <= pflag_d;
            sdata_q <= sdata_d;
            sdp_q   <= sdp_d;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= SEG_BLANK;
            an_q  <= '1;
            fd_q  <= 1'b0;
        end else begin
            led_q <= led_d;
            an_q  <= an_d;
            fd_q  <= fd_d;
        end
    end

    assign LED        = led_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_led_scan.sv
// Self-checking bench for seg_led_scan (DIGITS=4, SCAN_DIV=10, BLANK_CYCLES=2).
// A cycle model pushes expected pins each edge; a negedge sampler pops and compares.
module tb_seg_led_scan;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 10;
    localparam int BLANK    = 2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [7:0]  LED;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    logic [12:0] exp_q[$];

    logic [7:0] seg_tab [16] = '{
        8'h03, 8'h3F, 8'h49, 8'h19, 8'h35, 8'h91, 8'h81, 8'h3B,
        8'h01, 8'h11, 8'h21, 8'h85, 8'hC3, 8'h0D, 8'hC1, 8'hE1
    };

    int          m_cnt;
    int          m_dig;
    logic [15:0] m_pd, m_sd;
    logic [3:0]  m_pp, m_sp;
    bit          m_pf;
    bit          m_fe;
    bit          m_lz;
    logic [7:0]  m_led;
    logic [3:0]  m_an;

    logic [7:0]  cap_led [4];
    int          cap_blank;

    seg_led_scan #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data       (data),
        .dp         (dp),
        .LED        (LED),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected pins after this edge, then state update.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            m_dig = 0;
            m_pd  = '0;
            m_pp  = '0;
            m_sd  = '0;
            m_sp  = '0;
            m_pf  = 0;
        end else begin
            m_led = 8'hFF;
            m_an  = 4'hF;
            if (en && m_cnt >= BLANK) begin
                m_lz = 0;
`ifdef SEG_LED_LZB_EN
                if (m_dig > 0) begin
                    m_lz = 1;
                    for (int k = m_dig; k < DIGITS; k++)
                        if (m_sd[4*k +: 4] != 4'h0) m_lz = 0;
                end
`endif
                m_led = m_lz ? 8'hFF : seg_tab[m_sd[4*m_dig +: 4]];
                if (m_sp[m_dig]) m_led[0] = 1'b0;
                m_an[m_dig] = 1'b0;
            end
            m_fe = en && (m_cnt == SCAN_DIV - 1) && (m_dig == DIGITS - 1);
            exp_q.push_back({m_fe, m_an, m_led});
            if (m_fe) begin
                if (load) begin
                    m_sd = data;
                    m_sp = dp;
                end else if (m_pf) begin
                    m_sd = m_pd;
                    m_sp = m_pp;
                end
                m_pf = 0;
            end else if (load) begin
                m_pf = 1;
            end
            if (load) begin
                m_pd = data;
                m_pp = dp;
            end
            if (en) begin
                if (m_cnt == SCAN_DIV - 1) begin
                    m_cnt = 0;
                    m_dig = (m_dig == DIGITS - 1) ? 0 : m_dig + 1;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Scoreboard sampler.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            check("scoreboard", {19'b0, frame_done, an, LED},
                  {19'b0, exp_q.pop_front()});
        end
    end

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        check("fd_seen", frame_done, 1'b1);
    endtask

    task automatic wait_an(input logic [3:0] want);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== want && n < 200);
        check("an_seen", an, want);
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p);
        @(posedge clk);
        #2;
        data = d;
        dp   = p;
        load = 1'b1;
        @(posedge clk);
        #2;
        load = 1'b0;
    endtask

    // Record the LED pattern seen for each digit over one full frame.
    task automatic capture();
        for (int i = 0; i < 4; i++) cap_led[i] = 8'h00;
        cap_blank = 0;
        repeat (40) begin
            @(negedge clk);
            if (an == 4'hF) cap_blank++;
            for (int i = 0; i < 4; i++)
                if (an == ~(4'b0001 << i)) cap_led[i] = LED;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        data = '0;
        dp   = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_led", LED, 8'hFF);
        check("rst_an", an, 4'hF);
        check("rst_fd", frame_done, 1'b0);
        rst = 1'b0;
        en  = 1'b1;

        // First digit shows the zeroed shadow.
        wait_an(4'hE);
        check("init_d0", LED, 8'h03);

        // Reset mid-scan takes effect in the same cycle.
        wait_an(4'hB);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_led", LED, 8'hFF);
        check("mid_rst_an", an, 4'hF);
        check("mid_rst_fd", frame_done, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an == 4'hF && n < 50);
        check("post_rst_an", an, 4'hE);
        check("post_rst_lat", n, 4);

        // Decode of a mixed word.
        load_word(16'h1A2F, 4'b0000);
        wait_fd();
        capture();
        check("dec_d0", cap_led[0], 8'hE1);
        check("dec_d1", cap_led[1], 8'h49);
        check("dec_d2", cap_led[2], 8'h21);
        check("dec_d3", cap_led[3], 8'h3F);
        check("blank_cycles", cap_blank, 8);

        // Decimal point and frame period.
        load_word(16'h1A2F, 4'b0100);
        wait_fd();
        capture();
        check("dp_d2", cap_led[2], 8'h20);
        check("dp_d0", cap_led[0], 8'hE1);
        wait_fd();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        check("frame_period", n, 40);

        // Loads inside a frame must not tear it.
        wait_fd();
        repeat (4) @(posedge clk);
        load_word(16'h1111, 4'b0000);
        repeat (10) @(posedge clk);
        load_word(16'h2222, 4'b0000);
        wait_an(4'hB);
        check("tear_d2", LED, 8'h20);
        wait_an(4'h7);
        check("tear_d3", LED, 8'h3F);
        wait_fd();
        capture();
        for (int i = 0; i < 4; i++) check("tear_new", cap_led[i], 8'h49);

        // Load coinciding with the frame-end cycle.
        wait_fd();
        repeat (39) @(posedge clk);
        #2;
        data = 16'h3333;
        dp   = 4'b0000;
        load = 1'b1;
        @(posedge clk);
        #2;
        load = 1'b0;
        check("pflag_clear", dut.pflag_q, 1'b0);
        wait_fd();
        capture();
        for (int i = 0; i < 4; i++) check("edge_load", cap_led[i], 8'h19);

        // Pause mid-SHOW and resume at the held count.
        wait_an(4'hD);
        n = 1;
        repeat (2) begin
            @(negedge clk);
            if (an == 4'hD) n++;
        end
        @(posedge clk);
        #2;
        en = 1'b0;
        @(negedge clk);
        if (an == 4'hD) n++;
        repeat (15) begin
            @(negedge clk);
            check("pause", {frame_done, an, LED}, {1'b0, 4'hF, 8'hFF});
        end
        en = 1'b1;
        @(negedge clk);
        check("resume_an", an, 4'hD);
        if (an == 4'hD) n++;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (an != 4'hD) break;
            n++;
        end
        check("show_total", n, 8);

        // Leading zeros.
        load_word(16'h0050, 4'b0000);
        wait_fd();
        capture();
`ifdef SEG_LED_LZB_EN
        check("lz_d3", cap_led[3], 8'hFF);
        check("lz_d2", cap_led[2], 8'hFF);
`else
        check("lz_d3", cap_led[3], 8'h03);
        check("lz_d2", cap_led[2], 8'h03);
`endif
        check("lz_d1", cap_led[1], 8'h91);
        check("lz_d0", cap_led[0], 8'h03);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
